serial_add_sequencer: RTL and testbench

- Upstream feeder and downstream collector for the 8-bit bit-serial adder.
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- For each pair it drives the adder's operand inputs and START pulse window, samples the 9-bit SUM after a fixed latency, and presents each result over a valid/ready output.
- Makes the serial adder usable as a streaming stage.

---
 rtl/serial_add_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_serial_add_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// ============================================================================
// Module   : serial_add_sequencer
// Purpose  : Buffers operand pairs and feeds them to a bit-serial adder,
//            capturing each sum after a fixed latency into a valid/ready port.
//            Optional macro SEQ_SELFCHECK_EN adds a sticky sum self-check (o_err).
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_add_sequencer #(
    parameter int SIZE       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP      = 2,
    parameter int LATENCY    = 10,
    parameter int RELEASE    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [SIZE-1:0] i_in_a,
    input  logic [SIZE-1:0] i_in_b,
    output logic [SIZE-1:0] o_add_a,
    output logic [SIZE-1:0] o_add_b,
    output logic            o_add_start,
    input  logic [SIZE:0]   i_add_sum,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [SIZE:0]   o_out_sum,
    output logic            o_busy
`ifdef SEQ_SELFCHECK_EN
    ,
    output logic            o_err
`endif
);

    localparam int c_ptr_w  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
    localparam int c_max_t  = (LATENCY > SETUP) ? ((LATENCY > RELEASE) ? LATENCY : RELEASE)
                                                : ((SETUP > RELEASE) ? SETUP : RELEASE);
    localparam int c_tmr_w  = $clog2(c_max_t + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_tmr_w-1:0]   r_tmr;
    logic [SIZE-1:0]      r_mem_a [FIFO_DEPTH];
    logic [SIZE-1:0]      r_mem_b [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_in_ready;
    logic [SIZE-1:0]      r_add_a;
    logic [SIZE-1:0]      r_add_b;
    logic                 r_add_start;
    logic                 r_out_valid;
    logic [SIZE:0]        r_out_sum;

    logic                 w_push;
    logic                 w_pop;
    logic [c_cnt_w-1:0]   w_count_nxt;

    assign w_push = i_in_valid && r_in_ready;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + c_cnt_w'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - c_cnt_w'(1);
    end

    // Operand FIFO; ready is registered from the next count, so no pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr] <= i_in_a;
                r_mem_b[r_wr_ptr] <= i_in_b;
                r_wr_ptr          <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != c_cnt_w'(FIFO_DEPTH));
        end
    end

`ifdef SEQ_SELFCHECK_EN
    logic          r_err;
    logic [SIZE:0] w_expect;

    assign w_expect = {1'b0, r_add_a} + {1'b0, r_add_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (r_state == S_RUN && r_tmr == c_tmr_w'(LATENCY) && i_add_sum != w_expect)
            r_err <= 1'b1;
    end

    assign o_err = r_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tmr       <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
        end else begin
            // The output handshake may complete in any state, including DRAIN.
            if (r_out_valid && i_out_ready)
                r_out_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_tmr <= '0;
                    if (w_pop) begin
                        r_add_a <= r_mem_a[r_rd_ptr];
                        r_add_b <= r_mem_b[r_rd_ptr];
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_tmr == c_tmr_w'(SETUP - 1)) begin
                        r_tmr       <= '0;
                        r_add_start <= 1'b1;
                        r_state     <= S_RUN;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                S_RUN: begin
                    if (r_tmr == c_tmr_w'(LATENCY)) begin
                        r_tmr       <= '0;
                        r_add_start <= 1'b0;
                        r_out_sum   <= i_add_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_tmr == c_tmr_w'(RELEASE - 1)) begin
                        r_tmr   <= '0;
                        r_state <= S_RESULT;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                S_RESULT: begin
                    r_tmr <= '0;
                    if (!r_out_valid || i_out_ready)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_tmr   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_add_start = r_add_start;
    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// Testbench for serial_add_sequencer: behavioural adder, queue scoreboard and
// directed plus randomized operand traffic.
`default_nettype none

module tb_serial_add_sequencer;

    localparam int SIZE    = 8;
    localparam int DEPTH   = 4;
    localparam int SETUP   = 2;
    localparam int LATENCY = 10;
    localparam int RELEASE = 1;
    localparam int SW      = SIZE + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_in_valid = 1'b0;
    logic            o_in_ready;
    logic [SIZE-1:0] i_in_a = '0;
    logic [SIZE-1:0] i_in_b = '0;
    logic [SIZE-1:0] o_add_a;
    logic [SIZE-1:0] o_add_b;
    logic            o_add_start;
    logic [SIZE:0]   i_add_sum;
    logic            o_out_valid;
    logic            i_out_ready = 1'b0;
    logic [SIZE:0]   o_out_sum;
    logic            o_busy;
`ifdef SEQ_SELFCHECK_EN
    logic            o_err;
`endif

    always #5 clk = ~clk;

    serial_add_sequencer #(
        .SIZE(SIZE), .FIFO_DEPTH(DEPTH), .SETUP(SETUP), .LATENCY(LATENCY), .RELEASE(RELEASE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_a(i_in_a), .i_in_b(i_in_b),
        .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_start(o_add_start),
        .i_add_sum(i_add_sum),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_sum(o_out_sum),
        .o_busy(o_busy)
`ifdef SEQ_SELFCHECK_EN
        , .o_err(o_err)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural adder: garbage until START has been high for LATENCY cycles.
    int            rc = 0;
    logic [SIZE:0] junk = '0;
    logic [SIZE:0] corrupt = '0;
    always @(posedge clk) begin
        rc   <= o_add_start ? rc + 1 : 0;
        junk <= SW'($urandom);
    end
    assign i_add_sum = (rc >= LATENCY) ? (({1'b0, o_add_a} + {1'b0, o_add_b}) ^ corrupt) : junk;

    // Reference model state
    logic [SIZE:0]   exp_q[$];
    logic [SIZE-1:0] opa_q[$];
    logic [SIZE-1:0] opb_q[$];
    int              run_len = 0, vlen = 0, last_vlen = 0, bcnt = 0;
    logic            prev_busy = 1'b0, prev_valid = 1'b0;
    logic [SIZE-1:0] cur_a = '0, cur_b = '0;
    logic [SIZE:0]   last_sum = '0;

    task automatic flush_model();
        exp_q.delete(); opa_q.delete(); opb_q.delete();
        run_len = 0; vlen = 0; bcnt = 0;
        prev_busy = 1'b0; prev_valid = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_in_valid && o_in_ready) begin
                    opa_q.push_back(i_in_a);
                    opb_q.push_back(i_in_b);
                    exp_q.push_back(({1'b0, i_in_a} + {1'b0, i_in_b}) ^ corrupt);
                end
                if (o_busy && !prev_busy) begin
                    bcnt = 0;
                    if (opa_q.size() == 0) chk("spurious_pop", 1, 0);
                    else begin
                        cur_a = opa_q.pop_front();
                        cur_b = opb_q.pop_front();
                    end
                end else if (o_busy) begin
                    bcnt++;
                end
                if (o_busy) begin
                    chk("add_a", o_add_a, cur_a);
                    chk("add_b", o_add_b, cur_b);
                end
                if (o_out_valid && !prev_valid)
                    chk("pop_to_valid", bcnt, SETUP + LATENCY + 1);
                if (o_out_valid) begin
                    chk("start_while_valid", o_add_start, 0);
                    if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                    else begin
                        chk("out_sum", o_out_sum, exp_q[0]);
                        if (i_out_ready) begin
                            last_sum = o_out_sum;
                            void'(exp_q.pop_front());
                        end
                    end
                    vlen++;
                end else if (vlen != 0) begin
                    last_vlen = vlen;
                    vlen = 0;
                end
                if (o_add_start) run_len++;
                else if (run_len != 0) begin
                    chk("start_len", run_len, LATENCY + 1);
                    run_len = 0;
                end
                prev_busy  = o_busy;
                prev_valid = o_out_valid;
            end
        end
    end

    task automatic push(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        bit ok = 0;
        i_in_valid = 1'b1; i_in_a = a; i_in_b = b;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (o_in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("push_timeout", 0, 1);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_busy) begin done = 1; break; end
        end
        if (!done) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin : main
        int  sent;
        bit  acc;
        bit  seen;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready", o_in_ready, 1);
            chk("rst_out_valid", o_out_valid, 0);
            chk("rst_add_start", o_add_start, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_out_sum", o_out_sum, 0);
        end
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single adds, including carry-out
        i_out_ready = 1'b1;
        push(8'h5A, 8'h3C); wait_drain(100);
        chk("sum_5a_3c", last_sum, 9'h096);
        chk("valid_len_ready_high", last_vlen, 1);
        push(8'hFF, 8'h01); wait_drain(100);
        chk("sum_ff_01", last_sum, 9'h100);
        push(8'hFF, 8'hFF); wait_drain(100);
        chk("sum_ff_ff", last_sum, 9'h1FE);

        // FIFO fill: one pair in flight plus DEPTH queued
        i_out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(SIZE'($urandom), SIZE'($urandom));
        @(negedge clk);
        chk("full_in_ready", o_in_ready, 0);
        i_in_valid = 1'b1; i_in_a = SIZE'($urandom); i_in_b = SIZE'($urandom);
        repeat (10) @(negedge clk);
        chk("full_holds", o_in_ready, 0);
        @(posedge clk); #1;
        i_out_ready = 1'b1;
        push(i_in_a, i_in_b);
        wait_drain(600);

        // Backpressure for 20 cycles after capture
        i_out_ready = 1'b0;
        push(SIZE'($urandom), SIZE'($urandom));
        push(SIZE'($urandom), SIZE'($urandom));
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (o_out_valid) begin seen = 1; break; end
        end
        chk("bp_valid_seen", seen, 1);
        repeat (20) @(negedge clk);
        chk("bp_valid_held", o_out_valid, 1);
        chk("bp_no_start", o_add_start, 0);
        @(posedge clk); #1;
        i_out_ready = 1'b1;
        wait_drain(200);

        // Randomized traffic with random output backpressure
        sent = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 24 || exp_q.size() != 0 || o_busy); cyc++) begin
            i_out_ready = 1'($urandom_range(0, 1));
            if (!i_in_valid && sent < 24 && $urandom_range(0, 2) == 0) begin
                i_in_valid = 1'b1;
                i_in_a = SIZE'($urandom);
                i_in_b = SIZE'($urandom);
            end
            @(negedge clk);
            acc = i_in_valid && o_in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            if (acc) i_in_valid = 1'b0;
        end
        chk("random_sent", sent, 24);
        i_out_ready = 1'b1;
        wait_drain(200);

        // Reset during RUN cycle 5 with further pairs queued
        push(SIZE'($urandom), SIZE'($urandom));
        push(SIZE'($urandom), SIZE'($urandom));
        push(SIZE'($urandom), SIZE'($urandom));
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (o_add_start) begin seen = 1; break; end
        end
        chk("run_start_seen", seen, 1);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_start", o_add_start, 0);
        chk("mid_rst_valid", o_out_valid, 0);
        chk("mid_rst_ready", o_in_ready, 1);
        chk("mid_rst_busy", o_busy, 0);
        flush_model();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_fifo_empty", o_busy, 0);
        @(posedge clk); #1;
        push(8'h12, 8'h34); wait_drain(100);
        chk("post_rst_sum", last_sum, 9'h046);

`ifdef SEQ_SELFCHECK_EN
        chk("err_clear", o_err, 0);
        corrupt = 9'h004;
        push(8'h10, 8'h20); wait_drain(100);
        corrupt = '0;
        chk("err_set", o_err, 1);
        push(8'h01, 8'h02); wait_drain(100);
        chk("err_sticky", o_err, 1);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 chk("err_rst", o_err, 0);
        flush_model();
        @(negedge clk); #2 rst_n = 1'b1;
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
